// File: rtl/clk_divider.sv
// Integer clock divider: clk_out is a flop that toggles every DIV clk_in edges,
// giving a 50% duty clock of period 2*DIV with no combinational path to the output.
module clk_divider #(
    parameter int DIV = 5
) (
    input  logic clk_in,
    input  logic resetb,
    output logic clk_out
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("clk_divider: DIV must be in 1..65535");
    end

    // Declaration values give a defined start on FPGA and in simulation before the first reset edge.
    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;
    logic          clk_q = 1'b0;
    logic          clk_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        clk_d = clk_q;
        // Explicit wrap at DIV-1, so power-of-two DIV never relies on natural rollover.
        if (cnt_q == LAST) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed and randomised checks of four divider instances (DIV=1,3,4,5) against an
// edge-count model: after release, edge k gives clk_out = (k / DIV) mod 2.
module tb_clk_divider;

    logic clk_in = 1'b0;
    logic resetb = 1'b0;
    logic out1, out3, out4, out5;

    int total = 0;
    int bad   = 0;
    int k     = 0;  // rising edges with resetb=1 since the last reset edge

    always #5 clk_in = ~clk_in;

    clk_divider #(.DIV(1)) u1 (.clk_in(clk_in), .resetb(resetb), .clk_out(out1));
    clk_divider #(.DIV(3)) u3 (.clk_in(clk_in), .resetb(resetb), .clk_out(out3));
    clk_divider #(.DIV(4)) u4 (.clk_in(clk_in), .resetb(resetb), .clk_out(out4));
    clk_divider #(.DIV(5)) u5 (.clk_in(clk_in), .resetb(resetb), .clk_out(out5));

    function automatic logic model_out(input int div, input int kk, input logic rb);
        if (!rb) return 1'b0;
        return ((kk / div) % 2) == 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d k=%0d t=%0t", tag, obs, exp, k, $time);
        end
    endtask

    // One clk_in cycle: drive reset, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic rb);
        resetb = rb;
        @(posedge clk_in);
        if (rb) k++;
        else k = 0;
        #1;
        check("div1_out", int'(out1), int'(model_out(1, k, rb)));
        check("div3_out", int'(out3), int'(model_out(3, k, rb)));
        check("div4_out", int'(out4), int'(model_out(4, k, rb)));
        check("div5_out", int'(out5), int'(model_out(5, k, rb)));
        check("div4_cnt", int'(u4.cnt_q), rb ? (k % 4) : 0);
    endtask

    initial begin
        int rises;
        logic prev3;
        int n;

        // Reset held 3 cycles, then a long run covering all four divide ratios.
        repeat (3) step(1'b0);
        $display("txn reset3 k=%0d", k);
        repeat (40) step(1'b1);
        $display("txn run40 k=%0d out5=%b", k, out5);

        // One-cycle reset while DIV=5 output is high at cnt=2.
        step(1'b0);
        repeat (7) step(1'b1);
        check("div5_hi_pre", int'(out5), 1);
        check("div5_cnt2", int'(u5.cnt_q), 2);
        step(1'b0);
        check("div5_mid_rst", int'(out5), 0);
        repeat (12) step(1'b1);
        $display("txn midreset k=%0d", k);

        // DIV=3 over 100 cycles: rises at edges 3, 9, ..., 99.
        step(1'b0);
        rises = 0;
        prev3 = out3;
        repeat (100) begin
            step(1'b1);
            if (out3 && !prev3) rises++;
            prev3 = out3;
        end
        check("div3_rises", rises, (100 - 3) / 6 + 1);
        $display("txn div3_100 rises=%0d", rises);

        // Long reset: every sample must be 0.
        repeat (20) step(1'b0);
        $display("txn reset20 out5=%b", out5);

        // Random reset pulses and run lengths.
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, 3);
                repeat (n) step(1'b0);
                $display("txn rand%0d reset len=%0d", p, n);
            end else begin
                n = $urandom_range(1, 25);
                repeat (n) step(1'b1);
                $display("txn rand%0d run len=%0d k=%0d", p, n, k);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
